// File: rtl/score_display_pkg.sv
// Shared constants for the score display path.
// Segment codes are active-low, ordered gfedcba.
package score_display_pkg;

    localparam int MAX_VAL = 999;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decoder.sv
// BCD nibble to active-low 7-segment code.
// Non-decimal nibbles blank the display.
module seg7_decoder
    import score_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for one digit
    always_comb begin
        seg = SEG_BLANK;
        unique case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_bcd_display.sv
// Binary score to three registered BCD digits and HEX segments.
// Saturates at MAX_VAL; one cycle from input to all outputs.
module score_bcd_display #(
    parameter int BIN_W   = 10,
    parameter int MAX_VAL = 999
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [BIN_W-1:0] valor_bin,
    output logic [11:0]      valor_bcd,
    output logic [6:0]       digito0,
    output logic [6:0]       digito1,
    output logic [6:0]       digito2
);

    localparam logic [BIN_W-1:0] MAX_W = BIN_W'(MAX_VAL);

    logic [BIN_W-1:0]    sat_val;
    logic [BIN_W+11:0]   shift_r;
    logic [11:0]         bcd_c;
    logic [6:0]          seg0_c;
    logic [6:0]          seg1_c;
    logic [6:0]          seg2_c;

    // Clamp, then shift-and-add-3 across all input bits
    always_comb begin
        sat_val = (valor_bin > MAX_W) ? MAX_W : valor_bin;
        shift_r = {12'd0, sat_val};
        for (int i = 0; i < BIN_W; i++) begin
            for (int d = 0; d < 3; d++) begin
                if (shift_r[BIN_W+4*d +: 4] >= 4'd5) begin
                    shift_r[BIN_W+4*d +: 4] =
                        shift_r[BIN_W+4*d +: 4] + 4'd3;
                end
            end
            shift_r = shift_r << 1;
        end
        bcd_c = shift_r[BIN_W+11:BIN_W];
    end

    seg7_decoder u_dec0 (.bcd(bcd_c[3:0]),  .seg(seg0_c));
    seg7_decoder u_dec1 (.bcd(bcd_c[7:4]),  .seg(seg1_c));
    seg7_decoder u_dec2 (.bcd(bcd_c[11:8]), .seg(seg2_c));

    // Register BCD and segments together so the display stays coherent
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            valor_bcd <= 12'h000;
            digito0   <= score_display_pkg::SEG_0;
            digito1   <= score_display_pkg::SEG_0;
            digito2   <= score_display_pkg::SEG_0;
        end else begin
            valor_bcd <= bcd_c;
            digito0   <= seg0_c;
            digito1   <= seg1_c;
            digito2   <= seg2_c;
        end
    end

endmodule

// File: tb/tb_score_bcd_display.sv
// Directed and sweep bench for score_bcd_display.
// Expected values queue at drive time and retire one edge later.
module tb_score_bcd_display;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [9:0]  valor_bin;
    logic [11:0] valor_bcd;
    logic [6:0]  digito0;
    logic [6:0]  digito1;
    logic [6:0]  digito2;

    always #5 CLOCK_50 = ~CLOCK_50;

    score_bcd_display dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .valor_bin (valor_bin),
        .valor_bcd (valor_bcd),
        .digito0   (digito0),
        .digito1   (digito1),
        .digito2   (digito2)
    );

    typedef struct {
        logic [11:0] bcd;
        logic [6:0]  d0;
        logic [6:0]  d1;
        logic [6:0]  d2;
    } exp_t;

    logic [6:0] seg_tab [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    exp_t sb[$];
    exp_t prev;
    bit   have_prev = 1'b0;
    int   npass = 0;
    int   ntotal = 0;

    function automatic exp_t model(input bit rst, input int v);
        exp_t e;
        int s, h, t, u;
        s = (v > 999) ? 999 : v;
        if (rst) s = 0;
        h = s / 100;
        t = (s / 10) % 10;
        u = s % 10;
        e.bcd = {4'(h), 4'(t), 4'(u)};
        e.d0  = seg_tab[u];
        e.d1  = seg_tab[t];
        e.d2  = seg_tab[h];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs,
                       input logic [11:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".bcd"}, valor_bcd, e.bcd);
        chk({tag, ".d0"}, {5'd0, digito0}, {5'd0, e.d0});
        chk({tag, ".d1"}, {5'd0, digito1}, {5'd0, e.d1});
        chk({tag, ".d2"}, {5'd0, digito2}, {5'd0, e.d2});
    endtask

    task automatic step(input bit rst, input int v, input string tag);
        exp_t e;
        @(negedge CLOCK_50);
        reset     = rst;
        valor_bin = 10'(v);
        sb.push_back(model(rst, v));
        if (have_prev) chk_all({tag, "/hold"}, prev);
        @(posedge CLOCK_50);
        #1;
        e = sb.pop_front();
        chk_all(tag, e);
        prev      = e;
        have_prev = 1'b1;
    endtask

    initial begin
        reset     = 1'b1;
        valor_bin = 10'd555;

        step(1'b1, 555, "rst0");
        step(1'b1, 555, "rst1");
        step(1'b0, 555, "rel555");
        step(1'b0, 255, "lat255");
        step(1'b0, 0,   "b0");
        step(1'b0, 9,   "b9");
        step(1'b0, 10,  "b10");
        step(1'b0, 99,  "b99");
        step(1'b0, 100, "b100");
        step(1'b0, 999, "b999");
        step(1'b0, 1000, "sat1000");
        step(1'b0, 1023, "sat1023");

        step(1'b0, 7,    "btb7");
        step(1'b0, 8,    "btb8");
        step(1'b0, 1023, "btb1023");
        step(1'b0, 0,    "btb0");

        step(1'b0, 123, "pre_rst");
        step(1'b1, 456, "mid_rst");
        step(1'b0, 789, "post_rst");

        for (int v = 0; v < 1024; v++) begin
            step(1'b0, v, $sformatf("sweep%0d", v));
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
